// File: rtl/pixel_color_mixer.sv
// pixel_color_mixer
//   Sits directly after the drawing stage. For each descriptor strobe it latches
//   the sprite/block flags, block colour, sprite address and video_on, fetches
//   the sprite texel when needed, picks the visible colour
//   (sprite > block > background), applies blanking and drives registered
//   8-bit RGB to the VGA DAC.
//
// Ports
//   clk, reset        system clock, synchronous active-high reset
//   in_valid          one-cycle descriptor strobe, accepted only when idle
//   in_is_sprite      pixel lies inside an active sprite
//   in_is_block       background block is visible
//   in_block_color    block colour (RRRGGGBBB)
//   in_sprite_addr    sprite memory address of this pixel
//   video_on          1 = active video, 0 = blanking
//   mem_rd, mem_addr  sprite memory read request (one-cycle pulse)
//   mem_data          texel, valid MEM_LAT cycles after the mem_rd cycle
//   vga_r/g/b         registered RGB, held between out_valid pulses
//   out_valid         one-cycle pulse when vga_r/g/b take a new pixel
//   busy              FSM is not idle
//   overrun           sticky: a strobe was dropped because the FSM was busy
module pixel_color_mixer #(
  parameter int                  COLOR_W     = 9,
  parameter int                  ADDR_W      = 14,
  parameter int                  MEM_LAT     = 1,
  parameter logic [COLOR_W-1:0]  TRANSPARENT = 9'h1FE,
  parameter logic [COLOR_W-1:0]  BG_COLOR    = 9'h000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  input  logic               in_is_sprite,
  input  logic               in_is_block,
  input  logic [COLOR_W-1:0] in_block_color,
  input  logic [ADDR_W-1:0]  in_sprite_addr,
  input  logic               video_on,
  output logic               mem_rd,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic [COLOR_W-1:0] mem_data,
  output logic [7:0]         vga_r,
  output logic [7:0]         vga_g,
  output logic [7:0]         vga_b,
  output logic               out_valid,
  output logic               busy,
  output logic               overrun
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_RESOLVE
  } state_t;

  // WAIT lasts MEM_LAT-1 cycles; the counter counts down to zero, so it is
  // loaded with MEM_LAT-2. Unused when MEM_LAT is 1.
  localparam logic [1:0] WAIT_INIT = (MEM_LAT > 1) ? 2'(MEM_LAT - 2) : 2'd0;

  state_t             state;
  logic [1:0]         wait_cnt;
  logic               lat_sprite;
  logic               lat_block;
  logic [COLOR_W-1:0] lat_color;
  logic               lat_video_on;
  logic [COLOR_W-1:0] pixel;

  // 3-bit channel to 8 bits by bit replication so full scale maps to 8'hFF.
  function automatic logic [7:0] expand(input logic [2:0] c);
    return {c, c, c[2:1]};
  endfunction

  assign busy = (state != S_IDLE);

  // Priority select on latched values; mem_data is only meaningful in RESOLVE
  // of the sprite path, which is the only place pixel is consumed.
  always_comb begin
    pixel = BG_COLOR;
    if (lat_sprite && (mem_data != TRANSPARENT)) begin
      pixel = mem_data;
    end else if (lat_block && (lat_color != TRANSPARENT)) begin
      pixel = lat_color;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      wait_cnt     <= 2'd0;
      lat_sprite   <= 1'b0;
      lat_block    <= 1'b0;
      lat_color    <= '0;
      lat_video_on <= 1'b0;
      mem_rd       <= 1'b0;
      mem_addr     <= '0;
      vga_r        <= 8'h00;
      vga_g        <= 8'h00;
      vga_b        <= 8'h00;
      out_valid    <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      mem_rd    <= 1'b0;
      out_valid <= 1'b0;

      // Any strobe outside IDLE, including the RESOLVE cycle, is dropped.
      if (in_valid && (state != S_IDLE)) begin
        overrun <= 1'b1;
      end

      case (state)
        S_IDLE: begin
          if (in_valid) begin
            lat_sprite   <= in_is_sprite;
            lat_block    <= in_is_block;
            lat_color    <= in_block_color;
            lat_video_on <= video_on;
            mem_addr     <= in_sprite_addr;
            if (in_is_sprite) begin
              // Registered so the read pulse coincides with the FETCH cycle.
              mem_rd <= 1'b1;
              state  <= S_FETCH;
            end else begin
              state <= S_RESOLVE;
            end
          end
        end
        S_FETCH: begin
          if (MEM_LAT == 1) begin
            state <= S_RESOLVE;
          end else begin
            wait_cnt <= WAIT_INIT;
            state    <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (wait_cnt == 2'd0) begin
            state <= S_RESOLVE;
          end else begin
            wait_cnt <= wait_cnt - 2'd1;
          end
        end
        S_RESOLVE: begin
          if (lat_video_on) begin
            vga_r <= expand(pixel[8:6]);
            vga_g <= expand(pixel[5:3]);
            vga_b <= expand(pixel[2:0]);
          end else begin
            vga_r <= 8'h00;
            vga_g <= 8'h00;
            vga_b <= 8'h00;
          end
          out_valid <= 1'b1;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pixel_color_mixer.sv
// tb_pixel_color_mixer
//   Drives two instances of pixel_color_mixer (MEM_LAT=1 and MEM_LAT=3) from
//   the same descriptor stream. Each instance has its own sprite memory model
//   that returns the texel exactly MEM_LAT cycles after mem_rd and a poison
//   value at all other times.
module tb_pixel_color_mixer;

  localparam logic [8:0] POISON = 9'h155;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_is_sprite;
  logic        in_is_block;
  logic [8:0]  in_block_color;
  logic [13:0] in_sprite_addr;
  logic        video_on;

  logic        mem_rd_a, mem_rd_c;
  logic [13:0] mem_addr_a, mem_addr_c;
  logic [8:0]  mem_data_a, mem_data_c;
  logic [7:0]  r_a, g_a, b_a, r_c, g_c, b_c;
  logic        out_valid_a, out_valid_c;
  logic        busy_a, busy_c;
  logic        overrun_a, overrun_c;

  int num_compared = 0;
  int num_mismatched = 0;

  always #5 clk = ~clk;

  pixel_color_mixer #(.MEM_LAT(1)) dut_a (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_is_sprite(in_is_sprite),
    .in_is_block(in_is_block), .in_block_color(in_block_color),
    .in_sprite_addr(in_sprite_addr), .video_on(video_on),
    .mem_rd(mem_rd_a), .mem_addr(mem_addr_a), .mem_data(mem_data_a),
    .vga_r(r_a), .vga_g(g_a), .vga_b(b_a),
    .out_valid(out_valid_a), .busy(busy_a), .overrun(overrun_a)
  );

  pixel_color_mixer #(.MEM_LAT(3)) dut_c (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_is_sprite(in_is_sprite),
    .in_is_block(in_is_block), .in_block_color(in_block_color),
    .in_sprite_addr(in_sprite_addr), .video_on(video_on),
    .mem_rd(mem_rd_c), .mem_addr(mem_addr_c), .mem_data(mem_data_c),
    .vga_r(r_c), .vga_g(g_c), .vga_b(b_c),
    .out_valid(out_valid_c), .busy(busy_c), .overrun(overrun_c)
  );

  // Sprite memory contents used by the vectors.
  function automatic logic [8:0] texel(input logic [13:0] addr);
    case (addr)
      14'h0123: return 9'h038;
      14'h0200: return 9'h1FE;
      14'h0300: return 9'h0A5;
      14'h0400: return 9'h0DB;
      14'h0500: return 9'h1FE;
      default:  return POISON;
    endcase
  endfunction

  // Read pipelines: a request in cycle n produces data in cycle n+MEM_LAT,
  // independent of DUT reset.
  logic [2:0]  rd_pipe_a = '0;
  logic [13:0] ad_pipe_a = '0;
  logic [2:0]  rd_pipe_c = '0;
  logic [13:0] ad_pipe_c [3];

  initial for (int i = 0; i < 3; i++) ad_pipe_c[i] = '0;

  always @(posedge clk) begin
    rd_pipe_a    <= {rd_pipe_a[1:0], mem_rd_a};
    ad_pipe_a    <= mem_addr_a;
    rd_pipe_c    <= {rd_pipe_c[1:0], mem_rd_c};
    ad_pipe_c[0] <= mem_addr_c;
    ad_pipe_c[1] <= ad_pipe_c[0];
    ad_pipe_c[2] <= ad_pipe_c[1];
  end

  assign mem_data_a = rd_pipe_a[0] ? texel(ad_pipe_a)    : POISON;
  assign mem_data_c = rd_pipe_c[2] ? texel(ad_pipe_c[2]) : POISON;

  typedef struct {
    logic        is_sprite;
    logic        is_block;
    logic [8:0]  block_color;
    logic [13:0] addr;
    logic        von;
    logic [23:0] exp_rgb;
  } vec_t;

  vec_t vecs [12];

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    num_compared++;
    if (actual !== expected) begin
      num_mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Drives a descriptor strobe in the current negedge (cycle 0).
  task automatic apply_stimulus(input vec_t v);
    @(negedge clk);
    in_is_sprite   = v.is_sprite;
    in_is_block    = v.is_block;
    in_block_color = v.block_color;
    in_sprite_addr = v.addr;
    video_on       = v.von;
    in_valid       = 1'b1;
  endtask

  // Runs one pixel through both DUTs over an 8-cycle window. When dbl is set
  // a second strobe (v2) is presented in cycle 1 and must be dropped.
  task automatic run_vector(input string tag, input vec_t v, input bit dbl,
                            input vec_t v2, input logic exp_ovr);
    int ov_at_a = -1, ov_at_c = -1, ov_cnt_a = 0, ov_cnt_c = 0;
    int rd_cnt_a = 0, rd_cnt_c = 0, rd_at_a = -1;
    logic [13:0] rd_addr_a = '0, rd_addr_c = '0;
    logic [23:0] rgb_a = '0, rgb_c = '0;
    logic busy1_a = 1'b0, busy1_c = 1'b0;
    int exp_a, exp_c;
    exp_a = v.is_sprite ? 3 : 2;
    exp_c = v.is_sprite ? 5 : 2;
    apply_stimulus(v);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 1) begin
        busy1_a = busy_a;
        busy1_c = busy_c;
      end
      if (mem_rd_a) begin
        rd_cnt_a++;
        rd_at_a   = k;
        rd_addr_a = mem_addr_a;
      end
      if (mem_rd_c) begin
        rd_cnt_c++;
        rd_addr_c = mem_addr_c;
      end
      if (out_valid_a) begin
        ov_cnt_a++;
        ov_at_a = k;
        rgb_a   = {r_a, g_a, b_a};
      end
      if (out_valid_c) begin
        ov_cnt_c++;
        ov_at_c = k;
        rgb_c   = {r_c, g_c, b_c};
      end
      if (k == 1 && dbl) begin
        in_is_sprite   = v2.is_sprite;
        in_is_block    = v2.is_block;
        in_block_color = v2.block_color;
        in_sprite_addr = v2.addr;
        video_on       = v2.von;
      end else begin
        in_valid = 1'b0;
      end
    end
    check_output({tag, " busy_a@1"}, 32'(busy1_a), 32'd1);
    check_output({tag, " busy_c@1"}, 32'(busy1_c), 32'd1);
    check_output({tag, " out_valid_a cycle"}, 32'(ov_at_a), 32'(exp_a));
    check_output({tag, " out_valid_c cycle"}, 32'(ov_at_c), 32'(exp_c));
    check_output({tag, " out_valid_a count"}, 32'(ov_cnt_a), 32'd1);
    check_output({tag, " out_valid_c count"}, 32'(ov_cnt_c), 32'd1);
    check_output({tag, " rgb_a"}, 32'(rgb_a), 32'(v.exp_rgb));
    check_output({tag, " rgb_c"}, 32'(rgb_c), 32'(v.exp_rgb));
    check_output({tag, " rgb_a hold"}, 32'({r_a, g_a, b_a}), 32'(v.exp_rgb));
    check_output({tag, " rgb_c hold"}, 32'({r_c, g_c, b_c}), 32'(v.exp_rgb));
    check_output({tag, " mem_rd_a count"}, 32'(rd_cnt_a), 32'(v.is_sprite));
    check_output({tag, " mem_rd_c count"}, 32'(rd_cnt_c), 32'(v.is_sprite));
    if (v.is_sprite) begin
      check_output({tag, " mem_rd_a cycle"}, 32'(rd_at_a), 32'd1);
      check_output({tag, " mem_addr_a"}, 32'(rd_addr_a), 32'(v.addr));
      check_output({tag, " mem_addr_c"}, 32'(rd_addr_c), 32'(v.addr));
    end
    check_output({tag, " busy_a end"}, 32'(busy_a), 32'd0);
    check_output({tag, " busy_c end"}, 32'(busy_c), 32'd0);
    check_output({tag, " overrun_a"}, 32'(overrun_a), 32'(exp_ovr));
    check_output({tag, " overrun_c"}, 32'(overrun_c), 32'(exp_ovr));
  endtask

  task automatic check_idle_zero(input string tag, input logic exp_ovr);
    check_output({tag, " busy_a"}, 32'(busy_a), 32'd0);
    check_output({tag, " busy_c"}, 32'(busy_c), 32'd0);
    check_output({tag, " mem_rd_a"}, 32'(mem_rd_a), 32'd0);
    check_output({tag, " mem_rd_c"}, 32'(mem_rd_c), 32'd0);
    check_output({tag, " out_valid_a"}, 32'(out_valid_a), 32'd0);
    check_output({tag, " out_valid_c"}, 32'(out_valid_c), 32'd0);
    check_output({tag, " rgb_a"}, 32'({r_a, g_a, b_a}), 32'd0);
    check_output({tag, " rgb_c"}, 32'({r_c, g_c, b_c}), 32'd0);
    check_output({tag, " overrun_a"}, 32'(overrun_a), 32'(exp_ovr));
    check_output({tag, " overrun_c"}, 32'(overrun_c), 32'(exp_ovr));
  endtask

  initial begin
    vec_t none;
    vec_t spr;
    int late_ov;
    logic [23:0] late_rgb;

    //         sprite block  color    addr      von  rgb
    vecs[0]  = '{1'b0, 1'b1, 9'h1C0, 14'h0000, 1'b1, 24'hFF0000};
    vecs[1]  = '{1'b1, 1'b0, 9'h000, 14'h0123, 1'b1, 24'h00FF00};
    vecs[2]  = '{1'b1, 1'b1, 9'h007, 14'h0200, 1'b1, 24'h0000FF};
    vecs[3]  = '{1'b1, 1'b1, 9'h1FE, 14'h0200, 1'b1, 24'h000000};
    vecs[4]  = '{1'b1, 1'b0, 9'h000, 14'h0123, 1'b0, 24'h000000};
    vecs[5]  = '{1'b0, 1'b0, 9'h1C0, 14'h0000, 1'b1, 24'h000000};
    vecs[6]  = '{1'b0, 1'b1, 9'h1FE, 14'h0000, 1'b1, 24'h000000};
    vecs[7]  = '{1'b1, 1'b1, 9'h1C0, 14'h0300, 1'b1, 24'h4992B6};
    vecs[8]  = '{1'b0, 1'b1, 9'h1FF, 14'h0000, 1'b1, 24'hFFFFFF};
    vecs[9]  = '{1'b0, 1'b1, 9'h1FF, 14'h0000, 1'b0, 24'h000000};
    vecs[10] = '{1'b1, 1'b0, 9'h000, 14'h0400, 1'b1, 24'h6D6D6D};
    vecs[11] = '{1'b1, 1'b0, 9'h1FF, 14'h0500, 1'b1, 24'h000000};
    none = '{1'b0, 1'b1, 9'h007, 14'h0000, 1'b1, 24'h0000FF};
    spr  = '{1'b1, 1'b0, 9'h000, 14'h0123, 1'b1, 24'h00FF00};

    reset = 1'b1;
    in_valid = 1'b0;
    in_is_sprite = 1'b0;
    in_is_block = 1'b0;
    in_block_color = '0;
    in_sprite_addr = '0;
    video_on = 1'b0;
    repeat (3) @(negedge clk);
    check_idle_zero("reset", 1'b0);
    reset = 1'b0;

    for (int i = 0; i < 12; i++) begin
      run_vector($sformatf("vec%0d", i), vecs[i], 1'b0, none, 1'b0);
    end

    // Strobe during FETCH is dropped; first pixel still completes.
    run_vector("overrun_fetch", spr, 1'b1, none, 1'b1);
    repeat (10) @(negedge clk);
    check_output("overrun_a sticky", 32'(overrun_a), 32'd1);
    check_output("overrun_c sticky", 32'(overrun_c), 32'd1);

    // Reset held 3 cycles starting mid-FETCH; late texel must be ignored.
    apply_stimulus(spr);
    @(negedge clk);
    in_valid = 1'b0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check_idle_zero("reset_fetch", 1'b0);
    late_ov = 0;
    late_rgb = '0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (out_valid_a || out_valid_c || busy_a || busy_c) late_ov++;
      late_rgb = late_rgb | {r_a, g_a, b_a} | {r_c, g_c, b_c};
    end
    check_output("late return activity", 32'(late_ov), 32'd0);
    check_output("late return rgb", 32'(late_rgb), 32'd0);

    // Strobe in the RESOLVE cycle of a non-sprite pixel is also dropped.
    run_vector("overrun_resolve", none, 1'b1, spr, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", num_compared, num_mismatched);
    $finish;
  end

endmodule
